// File: rtl/operand_sequencer_if.sv
// Keypad-to-ALU bus for operand_sequencer: key events in, ALU operands out,
// ALU result back in, plus display/result status.
interface operand_sequencer_if;
  // key_valid is a one-cycle strobe with no back-pressure: the sequencer
  // consumes key_code on every clk edge where key_valid=1, in any state.
  logic              key_valid;
  logic [3:0]        key_code;
  logic signed [7:0] data_x;
  logic signed [7:0] data_y;
  logic              tula;
  logic signed [7:0] data_ula;
  logic              overflow;
  logic signed [7:0] disp_val;
  logic signed [7:0] result;
  logic              result_ovf;
  logic              result_valid;
  logic              entry_err;

  modport master (
    output key_valid, key_code, data_ula, overflow,
    input  data_x, data_y, tula, disp_val, result, result_ovf, result_valid, entry_err
  );

  modport slave (
    input  key_valid, key_code, data_ula, overflow,
    output data_x, data_y, tula, disp_val, result, result_ovf, result_valid, entry_err
  );
endinterface

// File: rtl/operand_sequencer.sv
// Assembles two signed decimal operands and an operator from keypad events and
// drives the add/sub ALU; OPSEQ_SATURATE_EN clamps overflowed results.
module operand_sequencer #(
    parameter int MAX_DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    operand_sequencer_if.slave  bus,
    output logic [1:0]          state_o
);

    localparam int CW = (MAX_DIGITS < 1) ? 1 : $clog2(MAX_DIGITS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DIGITS);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    localparam logic [3:0] K_ADD = 4'hA;
    localparam logic [3:0] K_SUB = 4'hB;
    localparam logic [3:0] K_EQ  = 4'hC;
    localparam logic [3:0] K_CLR = 4'hD;
    localparam logic [3:0] K_NEG = 4'hE;

    // Debug encoding on state_o: 0 first operand, 1 second operand, 2 exec, 3 done.
    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_EXEC = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q;
    logic [6:0]      mag_q;
    logic            neg_q;
    logic [CW-1:0]   cnt_q;
    logic [7:0]      data_x_q;
    logic [7:0]      data_y_q;
    logic            tula_q;
    logic [7:0]      result_q;
    logic            result_ovf_q;
    logic            result_valid_q;
    logic            entry_err_q;

    logic [7:0]      disp_w;
    logic [10:0]     prod_w;
    logic            is_digit;
    logic            is_op;
    logic            digit_ok;
    logic [7:0]      result_d;

    always_comb begin
        disp_w   = neg_q ? (8'd0 - {1'b0, mag_q}) : {1'b0, mag_q};
        prod_w   = 11'(mag_q) * 11'd10 + 11'(bus.key_code);
        is_digit = (bus.key_code <= 4'd9);
        is_op    = (bus.key_code == K_ADD) || (bus.key_code == K_SUB);
        digit_ok = (prod_w <= 11'd127) && (cnt_q != CNT_MAX);
    end

    // On overflow the clamp direction follows the first operand's sign.
    always_comb begin
`ifdef OPSEQ_SATURATE_EN
        if (bus.overflow) begin
            result_d = data_y_q[7] ? 8'h80 : 8'h7F;
        end else begin
            result_d = bus.data_ula;
        end
`else
        result_d = bus.data_ula;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_A;
            mag_q          <= '0;
            neg_q          <= 1'b0;
            cnt_q          <= '0;
            data_x_q       <= '0;
            data_y_q       <= '0;
            tula_q         <= 1'b0;
            result_q       <= '0;
            result_ovf_q   <= 1'b0;
            result_valid_q <= 1'b0;
            entry_err_q    <= 1'b0;
        end else begin
            entry_err_q <= 1'b0;
            if (bus.key_valid && bus.key_code == K_CLR) begin
                state_q        <= S_A;
                mag_q          <= '0;
                neg_q          <= 1'b0;
                cnt_q          <= '0;
                data_x_q       <= '0;
                data_y_q       <= '0;
                tula_q         <= 1'b0;
                result_q       <= '0;
                result_ovf_q   <= 1'b0;
                result_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    S_A, S_B: begin
                        if (bus.key_valid) begin
                            if (is_digit) begin
                                if (digit_ok) begin
                                    mag_q <= prod_w[6:0];
                                    cnt_q <= cnt_q + CNT_ONE;
                                end else begin
                                    entry_err_q <= 1'b1;
                                end
                            end else if (bus.key_code == K_NEG) begin
                                neg_q <= ~neg_q;
                            end else if (is_op) begin
                                tula_q <= (bus.key_code == K_SUB);
                                if (state_q == S_A) begin
                                    data_y_q <= disp_w;
                                    mag_q    <= '0;
                                    neg_q    <= 1'b0;
                                    cnt_q    <= '0;
                                    state_q  <= S_B;
                                end
                            end else if (bus.key_code == K_EQ) begin
                                if (state_q == S_A) begin
                                    entry_err_q <= 1'b1;
                                end else begin
                                    data_x_q <= disp_w;
                                    mag_q    <= '0;
                                    neg_q    <= 1'b0;
                                    cnt_q    <= '0;
                                    state_q  <= S_EXEC;
                                end
                            end
                        end
                    end
                    S_EXEC: begin
                        result_q       <= result_d;
                        result_ovf_q   <= bus.overflow;
                        result_valid_q <= 1'b1;
                        state_q        <= S_DONE;
                    end
                    S_DONE: begin
                        if (bus.key_valid) begin
                            if (is_digit) begin
                                mag_q          <= {3'b000, bus.key_code};
                                neg_q          <= 1'b0;
                                cnt_q          <= CNT_ONE;
                                result_valid_q <= 1'b0;
                                state_q        <= S_A;
                            end else if (is_op) begin
                                data_y_q       <= result_q;
                                tula_q         <= (bus.key_code == K_SUB);
                                result_valid_q <= 1'b0;
                                state_q        <= S_B;
                            end else if (bus.key_code == K_EQ) begin
                                data_y_q <= result_q;
                                state_q  <= S_EXEC;
                            end else if (bus.key_code == K_NEG) begin
                                entry_err_q <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= S_A;
                endcase
            end
        end
    end

    assign bus.data_x       = data_x_q;
    assign bus.data_y       = data_y_q;
    assign bus.tula         = tula_q;
    assign bus.disp_val     = disp_w;
    assign bus.result       = result_q;
    assign bus.result_ovf   = result_ovf_q;
    assign bus.result_valid = result_valid_q;
    assign bus.entry_err    = entry_err_q;
    assign state_o          = state_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer: directed key sequences, an arithmetic model of
// the calculator checked every cycle, and literal expectations at key points.
module tb_operand_sequencer;

  localparam int K_ADD = 10;
  localparam int K_SUB = 11;
  localparam int K_EQ  = 12;
  localparam int K_CLR = 13;
  localparam int K_NEG = 14;
  localparam int K_NOP = 15;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  operand_sequencer_if bus ();
  operand_sequencer_if bus2 ();
  logic [1:0] state;
  logic [1:0] state2;

  operand_sequencer #(.MAX_DIGITS(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state)
  );

  operand_sequencer #(.MAX_DIGITS(2)) dut2 (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus2),
    .state_o (state2)
  );

  // ALU stand-in: 8-bit signed add/sub with overflow
  logic signed [8:0] alu_full;
  always_comb begin
    alu_full = bus.tula ? ({bus.data_y[7], bus.data_y} - {bus.data_x[7], bus.data_x})
                        : ({bus.data_y[7], bus.data_y} + {bus.data_x[7], bus.data_x});
    bus.data_ula = alu_full[7:0];
    bus.overflow = alu_full[8] ^ alu_full[7];
  end
  assign bus2.data_ula = 8'sd0;
  assign bus2.overflow = 1'b0;

  // scoreboard counters
  int checks = 0;
  int failures = 0;
  bit cmp_en = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // calculator model: operands as plain integers
  int m_st = 0;   // 0 first operand, 1 second operand, 2 exec, 3 done
  int m_mag = 0, m_neg = 0, m_cnt = 0;
  int m_x = 0, m_y = 0, m_tula = 0;
  int m_res = 0, m_ovf = 0, m_rv = 0, m_err = 0;

  function automatic int m_disp();
    return (m_neg != 0) ? -m_mag : m_mag;
  endfunction

  task automatic m_reset();
    m_st = 0; m_mag = 0; m_neg = 0; m_cnt = 0;
    m_x = 0; m_y = 0; m_tula = 0;
    m_res = 0; m_ovf = 0; m_rv = 0; m_err = 0;
  endtask

  always @(posedge clk or posedge rst) begin
    int k, v, s;
    if (rst) begin
      m_reset();
    end else begin
      k = int'(bus.key_code);
      m_err = 0;
      if (bus.key_valid && k == K_CLR) begin
        m_reset();
      end else if (m_st == 2) begin
        s = (m_tula != 0) ? (m_y - m_x) : (m_y + m_x);
        m_ovf = (s > 127 || s < -128) ? 1 : 0;
        v = s;
        if (v > 127) v = v - 256;
        if (v < -128) v = v + 256;
`ifdef OPSEQ_SATURATE_EN
        if (m_ovf != 0) v = (m_y < 0) ? -128 : 127;
`endif
        m_res = v; m_rv = 1; m_st = 3;
      end else if (bus.key_valid) begin
        if (m_st == 0 || m_st == 1) begin
          if (k <= 9) begin
            v = m_mag * 10 + k;
            if (v > 127 || m_cnt == 3) m_err = 1;
            else begin m_mag = v; m_cnt++; end
          end else if (k == K_NEG) begin
            m_neg = (m_neg != 0) ? 0 : 1;
          end else if (k == K_ADD || k == K_SUB) begin
            m_tula = (k == K_SUB) ? 1 : 0;
            if (m_st == 0) begin
              m_y = m_disp(); m_mag = 0; m_neg = 0; m_cnt = 0; m_st = 1;
            end
          end else if (k == K_EQ) begin
            if (m_st == 0) m_err = 1;
            else begin
              m_x = m_disp(); m_mag = 0; m_neg = 0; m_cnt = 0; m_st = 2;
            end
          end
        end else if (m_st == 3) begin
          if (k <= 9) begin
            m_mag = k; m_neg = 0; m_cnt = 1; m_rv = 0; m_st = 0;
          end else if (k == K_ADD || k == K_SUB) begin
            m_y = m_res; m_tula = (k == K_SUB) ? 1 : 0; m_rv = 0; m_st = 1;
          end else if (k == K_EQ) begin
            m_y = m_res; m_st = 2;
          end else if (k == K_NEG) begin
            m_err = 1;
          end
        end
      end
    end
  end

  // compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      check("cyc_state",    int'(state), m_st);
      check("cyc_disp",     int'(bus.disp_val), m_disp());
      check("cyc_data_x",   int'(bus.data_x), m_x);
      check("cyc_data_y",   int'(bus.data_y), m_y);
      check("cyc_tula",     int'(bus.tula), m_tula);
      check("cyc_result",   int'(bus.result), m_res);
      check("cyc_res_ovf",  int'(bus.result_ovf), m_ovf);
      check("cyc_res_vld",  int'(bus.result_valid), m_rv);
      check("cyc_err",      int'(bus.entry_err), m_err);
    end
  end

  // driver tasks: inputs change on the falling edge
  task automatic send_key(input int code);
    bus.key_valid = 1'b1;
    bus.key_code  = 4'(code);
    @(posedge clk);
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.key_code  = 4'(K_NOP);
  endtask

  task automatic send_key2(input int code);
    bus2.key_valid = 1'b1;
    bus2.key_code  = 4'(code);
    @(posedge clk);
    @(negedge clk);
    bus2.key_valid = 1'b0;
    bus2.key_code  = 4'(K_NOP);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus.key_valid  = 1'b0;
    bus.key_code   = 4'(K_NOP);
    bus2.key_valid = 1'b0;
    bus2.key_code  = 4'(K_NOP);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    cmp_en = 1;
    check("rst_state",  int'(state), 0);
    check("rst_disp",   int'(bus.disp_val), 0);
    check("rst_result", int'(bus.result), 0);
    check("rst_rvalid", int'(bus.result_valid), 0);

    // 12 + 5
    send_key(1); send_key(2); send_key(K_ADD); send_key(5); send_key(K_NOP);
    send_key(K_EQ);
    check("add_y", int'(bus.data_y), 12);
    check("add_x", int'(bus.data_x), 5);
    check("add_tula", int'(bus.tula), 0);
    check("add_rv_early", int'(bus.result_valid), 0);
    idle(1);
    check("add_result", int'(bus.result), 17);
    check("add_ovf", int'(bus.result_ovf), 0);
    check("add_rv", int'(bus.result_valid), 1);

    // chain 17 - 7, repeat, then start fresh
    send_key(K_SUB); send_key(7); send_key(K_EQ);
    check("chain_y", int'(bus.data_y), 17);
    check("chain_x", int'(bus.data_x), 7);
    check("chain_tula", int'(bus.tula), 1);
    idle(1);
    check("chain_result", int'(bus.result), 10);
    send_key(K_EQ);
    check("rep_y", int'(bus.data_y), 10);
    send_key(9);
    check("rep_result", int'(bus.result), 3);
    check("rep_state", int'(state), 3);
    send_key(K_NEG);
    check("done_neg_err", int'(bus.entry_err), 1);
    send_key(4);
    check("new_rv", int'(bus.result_valid), 0);
    check("new_state", int'(state), 0);
    check("new_disp", int'(bus.disp_val), 4);
    send_key(K_CLR);

    // 100 - (-50) overflows
    send_key(1); send_key(0); send_key(0); send_key(K_SUB);
    send_key(5); send_key(0); send_key(K_NEG);
    check("neg_disp", int'(bus.disp_val), -50);
    send_key(K_EQ);
    check("ovf_y", int'(bus.data_y), 100);
    check("ovf_x", int'(bus.data_x), -50);
    check("ovf_tula", int'(bus.tula), 1);
    idle(1);
`ifdef OPSEQ_SATURATE_EN
    check("ovf_result", int'(bus.result), 127);
`else
    check("ovf_result", int'(bus.result), -106);
`endif
    check("ovf_flag", int'(bus.result_ovf), 1);
    send_key(K_CLR);

    // magnitude limit
    send_key(1); send_key(3); send_key(0);
    check("mag_err", int'(bus.entry_err), 1);
    check("mag_disp", int'(bus.disp_val), 13);
    idle(1);
    check("mag_err_pulse", int'(bus.entry_err), 0);
    send_key(K_CLR);

    // digit-count limit (MAX_DIGITS=3 and the 2-digit instance)
    send_key(0); send_key(0); send_key(7);
    check("cnt3_ok", int'(bus.entry_err), 0);
    send_key(1);
    check("cnt3_err", int'(bus.entry_err), 1);
    check("cnt3_disp", int'(bus.disp_val), 7);
    send_key(K_CLR);
    send_key2(0); send_key2(0);
    check("cnt2_ok", int'(bus2.entry_err), 0);
    send_key2(1);
    check("cnt2_err", int'(bus2.entry_err), 1);
    check("cnt2_disp", int'(bus2.disp_val), 0);
    idle(1);
    check("cnt2_pulse", int'(bus2.entry_err), 0);

    // '=' in S_A, operator swap in S_B, clear in S_B
    send_key(K_EQ);
    check("eqA_err", int'(bus.entry_err), 1);
    check("eqA_state", int'(state), 0);
    send_key(2); send_key(K_ADD); send_key(K_ADD); send_key(K_SUB);
    check("swap_tula", int'(bus.tula), 1);
    check("swap_state", int'(state), 1);
    send_key(6); send_key(K_CLR);
    check("clr_y", int'(bus.data_y), 0);
    check("clr_tula", int'(bus.tula), 0);
    check("clr_disp", int'(bus.disp_val), 0);

    // async reset during exec
    send_key(9); send_key(K_ADD); send_key(1); send_key(K_EQ);
    check("pre_rst_state", int'(state), 2);
    #1 rst = 1'b1;
    #1;
    check("arst_state", int'(state), 0);
    check("arst_x", int'(bus.data_x), 0);
    check("arst_y", int'(bus.data_y), 0);
    check("arst_result", int'(bus.result), 0);
    check("arst_rv", int'(bus.result_valid), 0);
    #1 rst = 1'b0;
    idle(1);
    send_key(3); send_key(K_ADD); send_key(4); send_key(K_EQ);
    idle(1);
    check("post_rst_result", int'(bus.result), 7);
    check("post_rst_rv", int'(bus.result_valid), 1);
    idle(2);

    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
